// File: rtl/kernel_ctrl_pkg.sv
// Shared types for the kernel control sequencer: FSM state encoding and
// control-protocol mode encodings.
package kernel_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int CTRL_HS    = 0;
   localparam int CTRL_CHAIN = 1;

endpackage

// File: rtl/kernel_ctrl_done_collector.sv
// Accumulates per-channel done pulses for the current run and reports when
// every enabled channel has finished.
module kernel_ctrl_done_collector #(
   parameter int C_NUM_CHANNELS = 4
) (
   input  logic                      ap_clk,
   input  logic                      areset,
   input  logic                      clear,
   input  logic                      update,
   input  logic [C_NUM_CHANNELS-1:0] mask,
   input  logic [C_NUM_CHANNELS-1:0] ch_done,
   output logic                      all_done
);

   logic [C_NUM_CHANNELS-1:0] done_r;

   always_ff @(posedge ap_clk) begin
      if (areset || clear) begin
         done_r <= '0;
      end else if (update) begin
         done_r <= done_r | (ch_done & mask);
      end
   end

   // Includes this cycle's pulses so the last done moves to DONE on its own edge.
   assign all_done = (((done_r | ch_done) & mask) == mask);

endmodule

// File: rtl/kernel_ctrl_chain.sv
// Kernel control sequencer: host ap_start/ap_continue handshake, per-channel
// start fan-out, done collection and run-length measurement.
module kernel_ctrl_chain
   import kernel_ctrl_pkg::*;
#(
   parameter int C_NUM_CHANNELS            = 4,
   parameter int C_XFER_SIZE_WIDTH         = 32,
   parameter int C_DEFAULT_LENGTH_IN_BYTES = 16384,
   parameter int C_CTRL_CHAIN              = 0,
   parameter int C_CYCLE_CNT_WIDTH         = 32
) (
   input  logic                         ap_clk,
   input  logic                         areset,
   input  logic                         ap_start,
   input  logic                         ap_continue,
   output logic                         ap_idle,
   output logic                         ap_done,
   output logic                         ap_ready,
   input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
   input  logic [C_NUM_CHANNELS-1:0]    ctrl_ch_enable,
   output logic [C_XFER_SIZE_WIDTH-1:0] ch_xfer_size_in_bytes,
   output logic [C_NUM_CHANNELS-1:0]    ch_start,
   input  logic [C_NUM_CHANNELS-1:0]    ch_done,
   output logic [C_CYCLE_CNT_WIDTH-1:0] last_run_cycles,
   output logic [1:0]                   dbg_state
);

   localparam logic [C_XFER_SIZE_WIDTH-1:0] DEFAULT_SIZE =
      C_XFER_SIZE_WIDTH'(C_DEFAULT_LENGTH_IN_BYTES);
   localparam bit IS_CHAIN = (C_CTRL_CHAIN == CTRL_CHAIN);

   state_t                         state_q;
   state_t                         state_d;
   logic [C_NUM_CHANNELS-1:0]      mask_r;
   logic [C_XFER_SIZE_WIDTH-1:0]   size_r;
   logic [C_CYCLE_CNT_WIDTH-1:0]   cnt_r;
   logic [C_CYCLE_CNT_WIDTH-1:0]   cnt_inc;
   logic [C_CYCLE_CNT_WIDTH-1:0]   last_r;
   logic                           start_edge;
   logic                           all_done;

   assign start_edge = (state_q == IDLE) && ap_start;
   assign cnt_inc    = (&cnt_r) ? cnt_r : cnt_r + C_CYCLE_CNT_WIDTH'(1);

   kernel_ctrl_done_collector #(
      .C_NUM_CHANNELS(C_NUM_CHANNELS)
   ) u_done_collector (
      .ap_clk   (ap_clk),
      .areset   (areset),
      .clear    (start_edge),
      .update   (state_q == RUN),
      .mask     (mask_r),
      .ch_done  (ch_done),
      .all_done (all_done)
   );

   // START decides on mask_r alone so a stray ch_done in that cycle cannot end the run.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (ap_start) state_d = START;
         START: state_d = (mask_r == '0) ? DONE : RUN;
         RUN:   if (all_done) state_d = DONE;
         DONE:  if (!IS_CHAIN || ap_continue) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (areset) begin
         state_q <= IDLE;
         mask_r  <= '0;
         size_r  <= DEFAULT_SIZE;
         cnt_r   <= '0;
         last_r  <= '0;
      end else begin
         state_q <= state_d;
         if (start_edge) begin
            mask_r <= ctrl_ch_enable;
            size_r <= (ctrl_xfer_size_in_bytes == '0) ? DEFAULT_SIZE : ctrl_xfer_size_in_bytes;
            cnt_r  <= '0;
         end else if (state_q == START || state_q == RUN) begin
            cnt_r <= cnt_inc;
         end
         if (state_q != DONE && state_d == DONE) begin
            last_r <= cnt_inc;
         end
      end
   end

   // Handshake: ap_start is a level sampled only in IDLE; ap_done is high for
   // every DONE cycle (one in hs mode, until ap_continue in chain mode);
   // ap_ready mirrors ap_done in hs mode and pulses in START in chain mode.
   assign ap_idle               = (state_q == IDLE);
   assign ap_done               = (state_q == DONE);
   assign ap_ready              = IS_CHAIN ? (state_q == START) : (state_q == DONE);
   assign ch_start              = (state_q == START) ? mask_r : '0;
   assign ch_xfer_size_in_bytes = size_r;
   assign last_run_cycles       = last_r;
   assign dbg_state             = state_q;

endmodule

// File: tb/tb_kernel_ctrl_chain.sv
// Directed bench for kernel_ctrl_chain: one hs-mode and one chain-mode instance
// with a queue of expected run lengths checked as each run completes.
module tb_kernel_ctrl_chain;

   logic        clk;
   logic        areset;
   logic        ap_start_hs;
   logic        ap_start_cc;
   logic        ap_continue;
   logic [31:0] size_in;
   logic [3:0]  en;
   logic [3:0]  ch_done;

   logic        hs_idle, hs_done, hs_ready;
   logic [31:0] hs_size, hs_last;
   logic [3:0]  hs_chs;
   logic [1:0]  hs_dbg;

   logic        cc_idle, cc_done, cc_ready;
   logic [31:0] cc_size, cc_last;
   logic [3:0]  cc_chs;
   logic [1:0]  cc_dbg;

   int          tests;
   int          fails;
   logic [31:0] exp_q[$];

   kernel_ctrl_chain #(.C_CTRL_CHAIN(0)) dut_hs (
      .ap_clk                  (clk),
      .areset                  (areset),
      .ap_start                (ap_start_hs),
      .ap_continue             (ap_continue),
      .ap_idle                 (hs_idle),
      .ap_done                 (hs_done),
      .ap_ready                (hs_ready),
      .ctrl_xfer_size_in_bytes (size_in),
      .ctrl_ch_enable          (en),
      .ch_xfer_size_in_bytes   (hs_size),
      .ch_start                (hs_chs),
      .ch_done                 (ch_done),
      .last_run_cycles         (hs_last),
      .dbg_state               (hs_dbg)
   );

   kernel_ctrl_chain #(.C_CTRL_CHAIN(1)) dut_cc (
      .ap_clk                  (clk),
      .areset                  (areset),
      .ap_start                (ap_start_cc),
      .ap_continue             (ap_continue),
      .ap_idle                 (cc_idle),
      .ap_done                 (cc_done),
      .ap_ready                (cc_ready),
      .ctrl_xfer_size_in_bytes (size_in),
      .ctrl_ch_enable          (en),
      .ch_xfer_size_in_bytes   (cc_size),
      .ch_start                (cc_chs),
      .ch_done                 (ch_done),
      .last_run_cycles         (cc_last),
      .dbg_state               (cc_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic sb_pop(input string tag, input logic [31:0] obs);
      check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check(tag, 64'(obs), 64'(exp_q.pop_front()));
   endtask

   task automatic check_hs_reset(input string tag);
      check({tag, "_idle"},  64'(hs_idle),  64'd1);
      check({tag, "_done"},  64'(hs_done),  64'd0);
      check({tag, "_ready"}, 64'(hs_ready), 64'd0);
      check({tag, "_chs"},   64'(hs_chs),   64'd0);
      check({tag, "_size"},  64'(hs_size),  64'd16384);
      check({tag, "_last"},  64'(hs_last),  64'd0);
      check({tag, "_state"}, 64'(hs_dbg),   64'd0);
   endtask

   // Starts one hs run; channel i pulses done in cycle di after START (cycle 0).
   task automatic hs_run(input logic [3:0] mask, input logic [31:0] size,
                         input int d0, input int d1, input int d2, input int d3,
                         input logic [3:0] start_stray, input int exp_done,
                         input logic [31:0] exp_size, input int ncyc);
      logic prev;
      en = mask;
      size_in = size;
      ap_start_hs = 1'b1;
      tick();
      ap_start_hs = 1'b0;
      en = ~mask;
      size_in = 32'h55;
      exp_q.push_back(32'(exp_done));
      check("hs_start_pulse", 64'(hs_chs), 64'(mask));
      check("hs_idle_low", 64'(hs_idle), 64'd0);
      check("hs_size", 64'(hs_size), 64'(exp_size));
      prev = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         ch_done = 4'b0;
         ch_done[0] = (c == d0);
         ch_done[1] = (c == d1);
         ch_done[2] = (c == d2);
         ch_done[3] = (c == d3);
         if (c == 0) ch_done = ch_done | start_stray;
         check("hs_done", 64'(hs_done), 64'(c == exp_done));
         check("hs_ready", 64'(hs_ready), 64'(c == exp_done));
         if (c == 1) check("hs_start_gone", 64'(hs_chs), 64'd0);
         if (hs_done && !prev) sb_pop("hs_last_run", hs_last);
         prev = hs_done;
         tick();
      end
      ch_done = 4'b0;
      check("hs_idle_after", 64'(hs_idle), 64'd1);
   endtask

   initial begin
      logic prev;
      tests = 0;
      fails = 0;
      areset = 1'b1;
      ap_start_hs = 1'b0;
      ap_start_cc = 1'b0;
      ap_continue = 1'b0;
      size_in = 32'd0;
      en = 4'b0;
      ch_done = 4'b0;
      repeat (3) tick();
      check_hs_reset("rst");
      check("rst_cc_idle", 64'(cc_idle), 64'd1);
      check("rst_cc_ready", 64'(cc_ready), 64'd0);
      check("rst_cc_size", 64'(cc_size), 64'd16384);
      areset = 1'b0;
      tick();

      // Full mask, default size, staggered dones: last at +20.
      hs_run(4'hF, 32'd0, 5, 9, 7, 20, 4'h0, 21, 32'd16384, 25);
      // Disabled channels pulse first and must not complete the run.
      hs_run(4'b0101, 32'd64, 6, 2, 8, 3, 4'h0, 9, 32'd64, 12);
      // Empty mask: START then DONE.
      hs_run(4'b0000, 32'd32, -1, -1, -1, -1, 4'h0, 1, 32'd32, 4);

      // Stray dones in IDLE and in the START cycle.
      ch_done = 4'hF;
      tick();
      tick();
      ch_done = 4'h0;
      hs_run(4'hF, 32'd8, 3, 4, 5, 6, 4'hF, 7, 32'd8, 10);

      // Reset in the middle of a run with two dones latched.
      en = 4'hF;
      size_in = 32'd0;
      ap_start_hs = 1'b1;
      tick();
      ap_start_hs = 1'b0;
      for (int c = 0; c < 4; c++) begin
         ch_done = 4'b0;
         ch_done[0] = (c == 1);
         ch_done[1] = (c == 2);
         check("mid_done_low", 64'(hs_done), 64'd0);
         if (c == 3) areset = 1'b1;
         tick();
      end
      ch_done = 4'b0;
      check_hs_reset("midrst");
      areset = 1'b0;
      tick();
      hs_run(4'hF, 32'd0, 5, 6, 2, 3, 4'h0, 7, 32'd16384, 10);

      // Chain mode: held DONE, early ready, back-to-back run with new args.
      en = 4'b0011;
      size_in = 32'd100;
      ap_start_cc = 1'b1;
      tick();
      exp_q.push_back(32'd3);
      exp_q.push_back(32'd3);
      prev = 1'b0;
      for (int c = 0; c < 20; c++) begin
         ch_done = 4'b0;
         ch_done[0] = (c == 1);
         ch_done[1] = (c == 2);
         ch_done[2] = (c == 16);
         if (c == 1) begin
            en = 4'b0100;
            size_in = 32'd200;
         end
         ap_continue = (c == 12) || (c == 17);
         if (c == 14) ap_start_cc = 1'b0;
         check("cc_done", 64'(cc_done), 64'((c >= 3 && c <= 12) || c == 17));
         check("cc_ready", 64'(cc_ready), 64'(c == 0 || c == 14));
         check("cc_idle", 64'(cc_idle), 64'(c == 13 || c >= 18));
         if (c == 0) begin
            check("cc_start1", 64'(cc_chs), 64'd3);
            check("cc_size1", 64'(cc_size), 64'd100);
         end
         if (c == 14) begin
            check("cc_start2", 64'(cc_chs), 64'd4);
            check("cc_size2", 64'(cc_size), 64'd200);
         end
         if (cc_done && !prev) sb_pop("cc_last_run", cc_last);
         prev = cc_done;
         tick();
      end
      ap_continue = 1'b0;
      ch_done = 4'b0;
      check("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
